// File: rtl/iob_ram_2p_fifo_ctrl.sv
// FIFO controller for an external two-port RAM with registered read data.
// Fill level is tracked explicitly, and the full/empty flags are registered from it.
module iob_ram_2p_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              rst_i,
  input  logic              w_en_i,
  input  logic [DATA_W-1:0] w_data_i,
  output logic              w_full_o,
  input  logic              r_en_i,
  output logic [DATA_W-1:0] r_data_o,
  output logic              r_empty_o,
  output logic [ADDR_W:0]   level_o,
  output logic              ext_mem_w_en_o,
  output logic [ADDR_W-1:0] ext_mem_w_addr_o,
  output logic [DATA_W-1:0] ext_mem_w_data_o,
  output logic              ext_mem_r_en_o,
  output logic [ADDR_W-1:0] ext_mem_r_addr_o,
  input  logic [DATA_W-1:0] ext_mem_r_data_i
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;

  logic [ADDR_W-1:0] w_ptr_reg;
  logic [ADDR_W-1:0] r_ptr_reg;
  logic [ADDR_W:0]   level_reg;
  logic [ADDR_W:0]   level_next;
  logic              full_reg;
  logic              empty_reg;
  logic              w_accept;
  logic              r_accept;

  // While either reset is asserted, no RAM access may leak out.
  assign w_accept = w_en_i & ~full_reg & ~rst_i & ~arst_i;
  assign r_accept = r_en_i & ~empty_reg & ~rst_i & ~arst_i;

  always_comb begin
    level_next = level_reg;
    case ({w_accept, r_accept})
      2'b10:   level_next = level_reg + (ADDR_W+1)'(1);
      2'b01:   level_next = level_reg - (ADDR_W+1)'(1);
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      w_ptr_reg <= '0;
      r_ptr_reg <= '0;
      level_reg <= '0;
      full_reg  <= 1'b0;
      empty_reg <= 1'b1;
    end else if (rst_i) begin
      w_ptr_reg <= '0;
      r_ptr_reg <= '0;
      level_reg <= '0;
      full_reg  <= 1'b0;
      empty_reg <= 1'b1;
    end else begin
      if (w_accept) w_ptr_reg <= w_ptr_reg + ADDR_W'(1);
      if (r_accept) r_ptr_reg <= r_ptr_reg + ADDR_W'(1);
      level_reg <= level_next;
      full_reg  <= (level_next == DEPTH);
      empty_reg <= (level_next == '0);
    end
  end

  assign w_full_o         = full_reg;
  assign r_empty_o        = empty_reg;
  assign level_o          = level_reg;
  assign ext_mem_w_en_o   = w_accept;
  assign ext_mem_w_addr_o = w_ptr_reg;
  assign ext_mem_w_data_o = w_data_i;
  assign ext_mem_r_en_o   = r_accept;
  assign ext_mem_r_addr_o = r_ptr_reg;
  assign r_data_o         = ext_mem_r_data_i;

endmodule

// File: tb/tb_iob_ram_2p_fifo_ctrl.sv
// Randomised and directed bench for iob_ram_2p_fifo_ctrl, with a RAM model,
// a queue reference model and a read-data scoreboard.
module tb_iob_ram_2p_fifo_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk_i = 1'b0;
  logic              arst_i;
  logic              rst_i;
  logic              w_en_i;
  logic [DATA_W-1:0] w_data_i;
  logic              w_full_o;
  logic              r_en_i;
  logic [DATA_W-1:0] r_data_o;
  logic              r_empty_o;
  logic [ADDR_W:0]   level_o;
  logic              ext_mem_w_en_o;
  logic [ADDR_W-1:0] ext_mem_w_addr_o;
  logic [DATA_W-1:0] ext_mem_w_data_o;
  logic              ext_mem_r_en_o;
  logic [ADDR_W-1:0] ext_mem_r_addr_o;
  logic [DATA_W-1:0] ext_mem_r_data_i;

  iob_ram_2p_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i            (clk_i),
    .arst_i           (arst_i),
    .rst_i            (rst_i),
    .w_en_i           (w_en_i),
    .w_data_i         (w_data_i),
    .w_full_o         (w_full_o),
    .r_en_i           (r_en_i),
    .r_data_o         (r_data_o),
    .r_empty_o        (r_empty_o),
    .level_o          (level_o),
    .ext_mem_w_en_o   (ext_mem_w_en_o),
    .ext_mem_w_addr_o (ext_mem_w_addr_o),
    .ext_mem_w_data_o (ext_mem_w_data_o),
    .ext_mem_r_en_o   (ext_mem_r_en_o),
    .ext_mem_r_addr_o (ext_mem_r_addr_o),
    .ext_mem_r_data_i (ext_mem_r_data_i)
  );

  always #5 clk_i = ~clk_i;

  // External two-port RAM with a registered read port.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk_i) begin
    if (ext_mem_w_en_o) mem[ext_mem_w_addr_o] <= ext_mem_w_data_o;
    if (ext_mem_r_en_o) ext_mem_r_data_i <= mem[ext_mem_r_addr_o];
  end

  int tests = 0;
  int fails = 0;

  logic [DATA_W-1:0] model_q [$];
  logic [DATA_W-1:0] exp_q   [$];
  int wcnt = 0;
  int rcnt = 0;
  bit rd_pend = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: read data appears one cycle after each accepted pop.
  always @(negedge clk_i) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        chk("r_data_unexpected", 1, 0);
      end else begin
        logic [DATA_W-1:0] e;
        e = exp_q.pop_front();
        chk("r_data", int'(r_data_o), int'(e));
      end
    end
    rd_pend = ext_mem_r_en_o;
  end

  // One clock of stimulus; everything observable is checked against the queue model.
  task automatic cycle(input bit we, input logic [DATA_W-1:0] wd, input bit re);
    bit exp_full, exp_empty, wa, ra;
    w_en_i = we; w_data_i = wd; r_en_i = re;
    @(negedge clk_i);
    exp_full  = (model_q.size() == DEPTH);
    exp_empty = (model_q.size() == 0);
    wa = we && !exp_full;
    ra = re && !exp_empty;
    chk("level", int'(level_o), model_q.size());
    chk("full", int'(w_full_o), int'(exp_full));
    chk("empty", int'(r_empty_o), int'(exp_empty));
    chk("mem_w_en", int'(ext_mem_w_en_o), int'(wa));
    chk("mem_r_en", int'(ext_mem_r_en_o), int'(ra));
    if (wa) begin
      chk("w_addr", int'(ext_mem_w_addr_o), wcnt % DEPTH);
      chk("w_data", int'(ext_mem_w_data_o), int'(wd));
    end
    if (ra) chk("r_addr", int'(ext_mem_r_addr_o), rcnt % DEPTH);
    $display("[TB] t=%0t we=%0b wd=%0d re=%0b level=%0d", $time, we, wd, re, level_o);
    if (ra) begin
      exp_q.push_back(model_q.pop_front());
      rcnt++;
    end
    if (wa) begin
      model_q.push_back(wd);
      wcnt++;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_clear();
    model_q.delete();
    wcnt = 0;
    rcnt = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_level"}, int'(level_o), 0);
    chk({tag, "_empty"}, int'(r_empty_o), 1);
    chk({tag, "_full"}, int'(w_full_o), 0);
    chk({tag, "_w_en"}, int'(ext_mem_w_en_o), 0);
    chk({tag, "_r_en"}, int'(ext_mem_r_en_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    arst_i = 1'b1; rst_i = 1'b0; w_en_i = 1'b0; r_en_i = 1'b0; w_data_i = '0;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk_i);
    #1 arst_i = 1'b0;

    // Fill, then overflow attempt
    for (int i = 0; i < 16; i++) cycle(1, 8'(32 + i), 0);
    cycle(1, 8'd99, 0);
    cycle(0, 0, 0);

    // Drain, then underflow attempt
    for (int i = 0; i < 16; i++) cycle(0, 0, 1);
    cycle(0, 0, 1);
    cycle(0, 0, 0);

    // Wrap-around
    for (int i = 0; i < 10; i++) cycle(1, 8'($urandom_range(0, 255)), 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 1);
    for (int i = 0; i < 12; i++) cycle(1, 8'(100 + i), 0);
    for (int i = 0; i < 12; i++) cycle(0, 0, 1);

    // Simultaneous push+pop at mid level, empty and full
    for (int i = 0; i < 5; i++) cycle(1, 8'($urandom_range(0, 255)), 0);
    for (int i = 0; i < 4; i++) cycle(1, 8'($urandom_range(0, 255)), 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1);
    cycle(1, 8'd7, 1);
    for (int i = 0; i < 15; i++) cycle(1, 8'($urandom_range(0, 255)), 0);
    cycle(1, 8'd200, 1);
    cycle(0, 0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle(bit'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), bit'($urandom_range(0, 1)));
    for (int i = 0; i < 17; i++) cycle(0, 0, 1);

    // Asynchronous reset between edges at level 7
    for (int i = 0; i < 7; i++) cycle(1, 8'($urandom_range(0, 255)), 0);
    cycle(0, 0, 0);
    #2;
    arst_i = 1'b1; w_en_i = 1'b1; r_en_i = 1'b1;
    #1;
    check_reset_outputs("arst");
    arst_i = 1'b0; w_en_i = 1'b0; r_en_i = 1'b0;
    model_clear();
    @(posedge clk_i);
    #1;

    // Synchronous clear at level 7
    for (int i = 0; i < 7; i++) cycle(1, 8'($urandom_range(0, 255)), 0);
    cycle(0, 0, 0);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("srst_before_edge_level", int'(level_o), 7);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check_reset_outputs("srst");
    model_clear();

    cycle(1, 8'd55, 0);
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/iob_ram_2p_fifo_ctrl.md
Name: iob_ram_2p_fifo_ctrl

Overview:
Synchronous FIFO controller that drives an external two-port RAM (one write port, one read port with registered read data) as its storage.
- Takes push/pop requests from a producer and a consumer.
- Generates the RAM write/read enables and addresses, and tracks fill level and full/empty status.
- Sits between datapath stages that need elastic buffering.
- The RAM is instantiated alongside the controller by the parent.

Parameters:
DATA_W, 8, data word width in bits.
ADDR_W, 4, RAM address width; FIFO depth = 2**ADDR_W.

Ports:
clk_i  input  1  clock; all state updates on rising edge.
arst_i  input  1  asynchronous active-high reset.
rst_i  input  1  synchronous active-high clear; same effect as arst_i, applied at clock edge.
w_en_i  input  1  push request.
w_data_i  input  DATA_W  push data.
w_full_o  output  1  FIFO full.
r_en_i  input  1  pop request.
r_data_o  output  DATA_W  pop data, valid the cycle after an accepted pop.
r_empty_o  output  1  FIFO empty.
level_o  output  ADDR_W+1  number of stored words, 0..2**ADDR_W.
ext_mem_w_en_o  output  1  RAM write enable.
ext_mem_w_addr_o  output  ADDR_W  RAM write address.
ext_mem_w_data_o  output  DATA_W  RAM write data.
ext_mem_r_en_o  output  1  RAM read enable.
ext_mem_r_addr_o  output  ADDR_W  RAM read address.
ext_mem_r_data_i  input  DATA_W  RAM read data, one cycle after the read enable.

Behaviour:
- Reset (arst_i async, or rst_i sync):
  - write pointer = 0, read pointer = 0, level_o = 0.
  - r_empty_o = 1, w_full_o = 0.
  - ext_mem_w_en_o = 0, ext_mem_r_en_o = 0.
  - Stored data is not cleared. Reset mid-operation discards all contents.
- Push accept: w_accept = w_en_i & ~w_full_o.
  - Combinational: ext_mem_w_en_o = w_accept, ext_mem_w_addr_o = write pointer, ext_mem_w_data_o = w_data_i.
  - Write pointer increments mod 2**ADDR_W on the same edge.
- Pop accept: r_accept = r_en_i & ~r_empty_o.
  - Combinational: ext_mem_r_en_o = r_accept, ext_mem_r_addr_o = read pointer.
  - Read pointer increments mod 2**ADDR_W on the same edge.
- Read latency: 1 cycle. r_data_o = ext_mem_r_data_i (pass-through). Valid only in the cycle after an accepted pop; undefined otherwise.
- Rejected requests:
  - push while full is dropped: no RAM write, no state change.
  - pop while empty is ignored: no RAM read, no state change.
- Flags are evaluated on the current state, before the edge:
  - full and push+pop together: only the pop is accepted; level decrements.
  - empty and push+pop together: only the push is accepted; level increments. No same-cycle bypass.
- Level update per edge:
  - w_accept & ~r_accept: +1.
  - r_accept & ~w_accept: -1.
  - both or neither: unchanged.
- Flag outputs, registered alongside level:
  - w_full_o = (level == 2**ADDR_W).
  - r_empty_o = (level == 0).
- Pointer wrap: pointers are ADDR_W bits and wrap from 2**ADDR_W-1 to 0. Full/empty derive from level, not from pointer compare.
- Ordering: strict FIFO order across wrap-around.

Test Plan:
- Defaults DATA_W=8, ADDR_W=4. Check reset: r_empty_o=1, w_full_o=0, level_o=0, both ext enables 0.
- Fill: push 32..47 on 16 consecutive cycles -> ext_mem_w_addr_o = 0..15. After the last push: w_full_o=1, level_o=16. A 17th push of 99 -> ext_mem_w_en_o=0, level_o stays 16.
- Drain: pop 16 times -> r_data_o = 32..47, each one cycle after its pop. Then r_empty_o=1, level_o=0. A further pop -> ext_mem_r_en_o=0.
- Wrap: push 10 and pop 10 words; then push 12 words 100..111 -> write addresses 10..15, 0..5. Popping returns 100..111 in order.
- Simultaneous push+pop:
  - at level 5 -> level stays 5, data order preserved.
  - at empty -> only the push is accepted, level 1.
  - at full -> only the pop is accepted, level 15.
- Reset mid-operation: at level 7, pulse arst_i asynchronously between edges -> outputs return to reset values immediately. Repeat with rst_i -> outputs clear at the next edge. A subsequent push of 55 and pop returns 55.
